// File: rtl/addsub_pkg.sv
// Shared types and saturation constants for the multi-cycle saturating adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int unsigned SAT_MAXW = 64;

  function automatic logic [SAT_MAXW-1:0] sat_max(input int unsigned w);
    logic [SAT_MAXW-1:0] one;
    one = {{(SAT_MAXW-1){1'b0}}, 1'b1};
    return (one << (w - 1)) - one;
  endfunction

  function automatic logic [SAT_MAXW-1:0] sat_min(input int unsigned w);
    logic [SAT_MAXW-1:0] one;
    one = {{(SAT_MAXW-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_sat_seq_cla_chunk.sv
// W-bit carry-lookahead adder slice; also exposes the carry into its top bit.
module cla_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded from cin and all lower generate/propagate terms.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      acc = cin;
      for (int unsigned k = 0; k <= i; k++) begin
        acc = g[k] | (p[k] & acc);
      end
      c[i+1] = acc;
    end
  end

  assign s     = p ^ c[W-1:0];
  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/addsub_sat_seq.sv
// Multi-cycle saturating two's-complement add/subtract, one CHUNK-bit slice per cycle.
module addsub_sat_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(unsigned'(WIDTH)));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(unsigned'(WIDTH)));

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0 || WIDTH > int'(SAT_MAXW)) begin : g_bad_params
    $error("addsub_sat_seq: WIDTH must be >= 2, <= 64 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b, result, fin_sum;
  logic [IDXW-1:0]  idx;
  logic             carry_reg, cin_msb, cout_msb;
  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             ch_cout, ch_cmsb;
  logic             last, v;

  assign ch_a = op_a[int'(idx)*CHUNK +: CHUNK];
  assign ch_b = op_b[int'(idx)*CHUNK +: CHUNK];
  assign last = (idx == IDXW'(NCH - 1));

  cla_chunk #(.W(CHUNK)) u_cla (
    .a     (ch_a),
    .b     (ch_b),
    .cin   (carry_reg),
    .s     (ch_s),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  // The A sign is read from op_a's MSB; the effective B sign lives in op_b's MSB.
  assign v = cin_msb ^ cout_msb;

  always_comb begin
    fin_sum = result;
    if (sat_en && v) begin
      fin_sum = op_a[WIDTH-1] ? SMIN : SMAX;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      cin_msb   <= 1'b0;
      cout_msb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      ovfl      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a      <= a;
            op_b      <= b ^ {WIDTH{sub}};
            carry_reg <= sub;
            idx       <= '0;
          end
        end
        RUN: begin
          result[int'(idx)*CHUNK +: CHUNK] <= ch_s;
          carry_reg <= ch_cout;
          if (last) begin
            cin_msb  <= ch_cmsb;
            cout_msb <= ch_cout;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        FIN: begin
          sum  <= fin_sum;
          ovfl <= v;
          zero <= (fin_sum == '0);
          neg  <= fin_sum[WIDTH-1];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sat_seq.sv
// Directed bench for addsub_sat_seq: default 16/4 plus 8/8 and 32/4 configurations.
module tb_addsub_sat_seq;

  logic clk, rst_n;

  logic        start16, sub16, sat16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, ovfl16, zero16, neg16;

  logic        start8, sub8, sat8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, ovfl8, zero8, neg8;

  logic        start32, sub32, sat32;
  logic [31:0] a32, b32, sum32;
  logic        busy32, done32, ovfl32, zero32, neg32;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  addsub_sat_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .sub(sub16),
    .sat_en(sat16), .busy(busy16), .done(done16), .sum(sum16), .ovfl(ovfl16),
    .zero(zero16), .neg(neg16)
  );

  addsub_sat_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .sat_en(sat8), .busy(busy8), .done(done8), .sum(sum8), .ovfl(ovfl8),
    .zero(zero8), .neg(neg8)
  );

  addsub_sat_seq #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .sub(sub32),
    .sat_en(sat32), .busy(busy32), .done(done32), .sum(sum32), .ovfl(ovfl32),
    .zero(zero32), .neg(neg32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch from the current time (just after a rising edge) and follow to done.
  task automatic op16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                      input logic isub, input logic isat, input logic [15:0] esum,
                      input logic ev, input logic ez, input logic en);
    int unsigned cyc;
    logic        busy_ok;
    a16 = ia; b16 = ib; sub16 = isub; sat16 = isat; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (!done16 && cyc < 20) begin
      if (!busy16) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".lat"},      cyc,     32'd5);
    check({tag, ".busy"},     busy_ok, 1'b1);
    check({tag, ".busyfall"}, busy16,  1'b0);
    check({tag, ".sum"},      sum16,   esum);
    check({tag, ".ovfl"},     ovfl16,  ev);
    check({tag, ".zero"},     zero16,  ez);
    check({tag, ".neg"},      neg16,   en);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned ndone;
    logic [15:0] seen;

    rst_n = 1'b0;
    start16 = 0; sub16 = 0; sat16 = 0; a16 = '0; b16 = '0;
    start8  = 0; sub8  = 0; sat8  = 0; a8  = '0; b8  = '0;
    start32 = 0; sub32 = 0; sat32 = 0; a32 = '0; b32 = '0;
    #12;
    check("rst.sum16",  sum16,  16'h0);
    check("rst.busy16", busy16, 1'b0);
    check("rst.done16", done16, 1'b0);
    check("rst.flags16", {ovfl16, zero16, neg16}, 3'b000);
    check("rst.sum8",   sum8,   8'h0);
    check("rst.sum32",  sum32,  32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    op16("add",     16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    op16("satpos",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    op16("wrap",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
    op16("satneg",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
    op16("subzero", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    op16("subneg",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);

    // Extra start pulses while busy must be ignored.
    a16 = 16'h0100; b16 = 16'h0023; sub16 = 1'b0; sat16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start16 = 1'b0; sub16 = 1'b0;
    ndone = 0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      if (done16) begin
        ndone++;
        seen = sum16;
      end
      @(posedge clk); #1;
    end
    check("busystart.ndone", ndone, 32'd1);
    check("busystart.sum",   seen,  16'h0123);

    // Back-to-back: second start sits in the done cycle.
    op16("b2b1", 16'h0010, 16'h0020, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    op16("b2b2", 16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);

    // Reset while RUN is on chunk index 2.
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midrst.busy", busy16, 1'b0);
    check("midrst.sum",  sum16,  16'h0);
    check("midrst.done", done16, 1'b0);
    check("midrst.ovfl", ovfl16, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done16) ndone++;
    end
    check("midrst.nodone", ndone, 32'd0);
    op16("afterrst", 16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);

    // WIDTH=8, CHUNK=8: single chunk, two-cycle latency.
    a8 = 8'h7F; b8 = 8'h7F; sub8 = 1'b0; sat8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w8.lat",  cyc,   32'd2);
    check("w8.sum",  sum8,  8'h7F);
    check("w8.ovfl", ovfl8, 1'b1);
    check("w8.neg",  neg8,  1'b0);

    // WIDTH=32, CHUNK=4: wrap on overflow, nine-cycle latency.
    a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; sat32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 0;
    while (!done32 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w32.lat",  cyc,    32'd9);
    check("w32.sum",  sum32,  32'h8000_0000);
    check("w32.ovfl", ovfl32, 1'b1);
    check("w32.neg",  neg32,  1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
